// File: rtl/enc_pkg.sv
// Shared defaults and the one-hot to index/error decode used by onehot_dec_fifo.
// The decode works on a fixed maximum width so any OH_W up to OH_MAX can share it.
package enc_pkg;

   localparam int OH_W_DEF  = 15;
   localparam int BIN_W_DEF = 4;
   localparam int DEPTH_DEF = 4;

   localparam int OH_MAX = 64;
   localparam int IDX_W  = $clog2(OH_MAX);

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             err;
   } dec_t;

   // Lowest set bit wins; anything other than exactly one set bit is an error.
   function automatic dec_t onehot_decode(input logic [OH_MAX-1:0] vec);
      dec_t d;
      d.idx = '0;
      for (int i = OH_MAX - 1; i >= 0; i--) begin
         if (vec[i]) d.idx = IDX_W'(i);
      end
      d.err = ($countones(vec) != 1);
      return d;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head data reads as zero while empty.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module sync_fifo #(
   parameter  int WIDTH = 5,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_fire;
   logic             rd_fire;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign wr_fire = wr_en && !full;
   assign rd_fire = rd_en && !empty;

   // NOTE: storage has no reset; empty gates rd_data so stale words never reach the output.
   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_fire, rd_fire})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/onehot_dec_fifo.sv
// Decodes one-hot vectors into {index, err} and buffers them for a downstream consumer.
// Also keeps a saturating count of accepted malformed vectors.
module onehot_dec_fifo
   import enc_pkg::*;
#(
   parameter  int OH_W  = OH_W_DEF,
   parameter  int BIN_W = BIN_W_DEF,
   parameter  int DEPTH = DEPTH_DEF,
   localparam int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [OH_W-1:0]  in,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BIN_W-1:0] out,
   output logic             out_err,
   output logic [LVL_W-1:0] level,
   output logic [7:0]       err_cnt
);

   dec_t             dec;
   logic             run;
   logic             full;
   logic             empty;
   logic             wr_fire;
   logic [BIN_W:0]   rd_data;
   logic             unused_dec_bits;

   assign dec             = onehot_decode(OH_MAX'(in));
   assign unused_dec_bits = ^dec.idx;

   // run holds in_ready low during reset and rises on the first edge after release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) run <= 1'b0;
      else      run <= 1'b1;
   end

   assign in_ready  = run && !full;
   assign wr_fire   = in_valid && in_ready;
   assign out_valid = !empty;

   sync_fifo #(
      .WIDTH (BIN_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_fire),
      .wr_data ({dec.idx[BIN_W-1:0], dec.err}),
      .rd_en   (out_ready),
      .rd_data (rd_data),
      .level   (level),
      .full    (full),
      .empty   (empty)
   );

   assign {out, out_err} = rd_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt <= '0;
      end else if (wr_fire && dec.err && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_onehot_dec_fifo.sv
// Directed bench for onehot_dec_fifo: the stimulus queues hand-computed
// {index, err} results and a monitor pops them on every output transfer.
module tb_onehot_dec_fifo;

   localparam int OH_W  = 15;
   localparam int BIN_W = 4;
   localparam int DEPTH = 4;
   localparam int LVL_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [BIN_W-1:0] idx;
      logic             err;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic [OH_W-1:0]  in = '0;
   logic             out_ready = 1'b0;
   logic             in_ready;
   logic             out_valid;
   logic [BIN_W-1:0] out;
   logic             out_err;
   logic [LVL_W-1:0] level;
   logic [7:0]       err_cnt;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   onehot_dec_fifo #(
      .OH_W  (OH_W),
      .BIN_W (BIN_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in        (in),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_err   (out_err),
      .level     (level),
      .err_cnt   (err_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   // Inputs change 1 time unit after a rising edge and stay stable until the next one.
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [OH_W-1:0] v, input int idx, input bit err, input bit accept);
      exp_t e;
      in       = v;
      in_valid = 1'b1;
      if (accept) begin
         e.idx = BIN_W'(idx);
         e.err = err;
         exp_q.push_back(e);
      end
      step();
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) step();
      step();
      check("drain_empty", exp_q.size(), 0);
      check("drain_level", 32'(level), 0);
   endtask

   // Monitor: a head transfer happens on the next edge whenever out_valid and out_ready are both high.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_out: got idx %0d err %0d, want no entry", out, out_err);
            end else begin
               e = exp_q.pop_front();
               check("out_idx", 32'(out), 32'(e.idx));
               check("out_err", 32'(out_err), 32'(e.err));
            end
         end
      end
   end

   initial begin
      #100us;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      #12;
      check("rst_level", 32'(level), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out", 32'(out), 0);
      check("rst_out_err", 32'(out_err), 0);
      check("rst_err_cnt", 32'(err_cnt), 0);
      check("rst_in_ready", 32'(in_ready), 0);
      #10 rst = 1'b1;
      #1 check("in_ready_before_edge", 32'(in_ready), 0);
      step();
      check("in_ready_after_release", 32'(in_ready), 1);

      // Single vector, one-cycle latency
      out_ready = 1'b1;
      put(15'h0010, 4, 1'b0, 1'b1);
      in_valid = 1'b0;
      check("t1_out_valid", 32'(out_valid), 1);
      check("t1_out", 32'(out), 4);
      check("t1_out_err", 32'(out_err), 0);
      check("t1_level", 32'(level), 1);
      drain();

      // Zero-hot then multi-hot
      put(15'h0000, 0, 1'b1, 1'b1);
      put(15'h0006, 1, 1'b1, 1'b1);
      drain();
      check("t2_err_cnt", 32'(err_cnt), 2);

      // Fill to full, drop the fifth vector, hold head while stalled
      out_ready = 1'b0;
      put(15'h0004, 2, 1'b0, 1'b1);
      put(15'h0002, 1, 1'b0, 1'b1);
      put(15'h4000, 14, 1'b0, 1'b1);
      put(15'h0300, 8, 1'b1, 1'b1);
      check("t3_level_full", 32'(level), 4);
      check("t3_in_ready_full", 32'(in_ready), 0);
      put(15'h0000, 0, 1'b1, 1'b0);
      in_valid = 1'b0;
      check("t3_level_after_drop", 32'(level), 4);
      check("t3_head_out", 32'(out), 2);
      check("t3_head_err", 32'(out_err), 0);
      check("t3_err_cnt", 32'(err_cnt), 3);
      step(2);
      check("t3_hold_out", 32'(out), 2);
      check("t3_hold_level", 32'(level), 4);
      drain();
      check("t3_out_valid_empty", 32'(out_valid), 0);

      // Steady streaming at level 2 across pointer wrap
      out_ready = 1'b0;
      put(15'h2000, 13, 1'b0, 1'b1);
      put(15'h1000, 12, 1'b0, 1'b1);
      check("t4_level_start", 32'(level), 2);
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         put(OH_W'(1) << k, k, 1'b0, 1'b1);
         check("t4_level_stream", 32'(level), 2);
      end
      drain();
      check("t4_err_cnt", 32'(err_cnt), 3);

      // Error counter saturation
      out_ready = 1'b1;
      for (int k = 0; k < 260; k++) put(15'h0000, 0, 1'b1, 1'b1);
      in_valid = 1'b0;
      check("t5_err_cnt_sat", 32'(err_cnt), 255);
      put(15'h0000, 0, 1'b1, 1'b1);
      in_valid = 1'b0;
      check("t5_err_cnt_held", 32'(err_cnt), 255);
      drain();

      // Asynchronous reset with entries buffered
      out_ready = 1'b0;
      put(15'h0001, 0, 1'b0, 1'b1);
      put(15'h0020, 5, 1'b0, 1'b1);
      put(15'h0040, 6, 1'b0, 1'b1);
      in_valid = 1'b0;
      check("t6_level_before", 32'(level), 3);
      #2 rst = 1'b0;
      exp_q.delete();
      #1;
      check("t6_level_async", 32'(level), 0);
      check("t6_out_valid_async", 32'(out_valid), 0);
      check("t6_err_cnt_async", 32'(err_cnt), 0);
      check("t6_out_async", 32'(out), 0);
      check("t6_in_ready_async", 32'(in_ready), 0);
      in        = 15'h0010;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      check("t6_level_in_rst", 32'(level), 0);
      check("t6_err_cnt_in_rst", 32'(err_cnt), 0);
      in_valid = 1'b0;
      #3 rst = 1'b1;
      step();
      check("t6_in_ready_release", 32'(in_ready), 1);
      check("t6_level_release", 32'(level), 0);
      put(15'h0008, 3, 1'b0, 1'b1);
      drain();
      check("t6_err_cnt_final", 32'(err_cnt), 0);

      check("final_queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/onehot_dec_fifo.md
ONEHOT_DEC_FIFO -- requirements
Module: onehot_dec_fifo

Interface
REQ-001 The block SHALL expose parameter OH_W, default 15, the width of the one-hot input vector.
REQ-002 The block SHALL expose parameter BIN_W, default 4, the width of the binary index output.
REQ-003 The block SHALL expose parameter DEPTH, default 4, the buffer depth in entries (power of two, at least 2).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous reset, active when low.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream encoder vector valid.
REQ-008 The block SHALL have port in, input, OH_W bits: one-hot vector from the upstream enc_bin2onehot stage.
REQ-009 The block SHALL have port in_ready, output, 1 bit: buffer can accept this cycle.
REQ-010 The block SHALL have port out_valid, output, 1 bit: head entry available.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream consumes head entry.
REQ-012 The block SHALL have port out, output, BIN_W bits: decoded index of the head entry.
REQ-013 The block SHALL have port out_err, output, 1 bit: head entry was zero-hot or multi-hot.
REQ-014 The block SHALL have port level, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-015 The block SHALL have port err_cnt, output, 8 bits: saturating count of accepted bad vectors.

Function
REQ-016 A transfer-in SHALL occur on a clk edge where in_valid=1 and in_ready=1; a transfer-out SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-017 in_ready SHALL equal (level != DEPTH), independent of out_ready (no same-cycle pass-through when full).
REQ-018 Decode SHALL be: exactly one bit k set -> index k, err=0; zero vector -> index 0, err=1; several bits set -> index of lowest set bit, err=1.
REQ-019 Decode SHALL be combinational on in; {index, err} SHALL be written into the buffer on transfer-in.
REQ-020 Latency SHALL be one cycle: an entry written into an empty buffer at edge N SHALL make out_valid=1 after edge N; no combinational in-to-out bypass.
REQ-021 out_valid SHALL equal (level != 0); out and out_err SHALL present the oldest entry.
REQ-022 While out_valid=1 and out_ready=0, out and out_err SHALL be held stable.
REQ-023 Simultaneous transfer-in and transfer-out SHALL leave level unchanged and preserve FIFO order.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 err_cnt SHALL increment by 1 on each transfer-in whose decoded err=1 and SHALL saturate at 255.
REQ-026 in_valid with in_ready=0 SHALL be ignored: no write, no err_cnt change.
REQ-027 out_ready with out_valid=0 SHALL be ignored: level SHALL not underflow.

Reset
REQ-028 rst low SHALL asynchronously clear pointers, level=0, out_valid=0, out=0, out_err=0 and err_cnt=0.
REQ-029 in_ready SHALL be 0 while rst is low and 1 from the first cycle after release.
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries; no transfer SHALL occur on the edge coinciding with rst low.

Structure
REQ-031 OH_W, BIN_W and DEPTH defaults, plus the onehot-to-index/err decode function, SHALL live in a shared package enc_pkg.
REQ-032 Storage and pointer logic SHALL be a sub-module sync_fifo (parameterised width BIN_W+1, depth DEPTH); decode and err_cnt SHALL stay in the top level.

Verification
REQ-033 The bench SHALL drive in=15'h0010 with out_ready=1 -> next cycle out_valid=1, out=4, out_err=0, level=1.
REQ-034 The bench SHALL drive in=0, then in=15'h0006 -> outputs {0,err=1} then {1,err=1}; err_cnt=2.
REQ-035 The bench SHALL push 5 vectors with out_ready=0 -> level=4, in_ready=0, 5th dropped; drain yields first 4 in order.
REQ-036 With level=2, the bench SHALL run 10 cycles of in_valid=1 and out_ready=1 -> level stays 2; outputs ordered across pointer wrap.
REQ-037 The bench SHALL push 260 zero vectors while draining -> err_cnt=255 and held.
REQ-038 The bench SHALL assert rst low with level=3 between edges -> level=0, out_valid=0 and err_cnt=0 immediately; in_ready=1 one cycle after release.
